// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receiver FIFO head to its consumer.
interface uart_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a show-ahead FIFO.
// Reports framing errors (one pulse per low line) and sticky overrun.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    uart_rx_fifo_if.master              m,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int CPB  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rxs;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_done;
    logic          half_done;

    assign rxs       = sync[1];
    assign bit_done  = timer == TW'(CPB - 1);
    assign half_done = timer == TW'(HALF - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            timer     <= timer + 1'b1;
            unique case (state)
                IDLE: begin
                    timer <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (half_done) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer          <= '0;
                        shreg[bit_idx] <= rxs;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end
                end
                BRK: begin
                    timer <= '0;
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr;

    assign push = (state == STOP) && bit_done && rxs;
    assign pop  = m.m_valid && m.m_ready;
    assign full = level == LW'(FIFO_DEPTH);
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign wr   = push && (!full || pop);

    assign m.m_valid = level != '0;
    assign m.m_data  = m.m_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level <= level + LW'(wr) - LW'(pop);
            if (push && !wr) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based reference receiver
// that is checked against the DUT every cycle.
module tb_uart_rx_fifo;
    localparam int CPB   = 434;
    localparam int HALF  = 217;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       clr_overrun = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic [2:0] level;

    uart_rx_fifo_if s ();

    uart_rx_fifo #(
        .CLK_HZ(50000000),
        .BAUD(115200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .m(s),
        .frame_err(frame_err),
        .overrun(overrun),
        .clr_overrun(clr_overrun),
        .level(level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int nferr = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference receiver: spec-level timing on a 2-cycle-delayed line
    logic [7:0] q[$];
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    bit         s1 = 1'b1;
    bit         s2 = 1'b1;
    bit         seen = 1'b1;
    bit         mrst = 1'b0;

    task automatic tick();
        @(posedge clk);
        m_ferr = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_ovr = 1'b0;
            s1 = 1'b1;
            s2 = 1'b1;
            seen = 1'b1;
            mrst = 1'b1;
            return;
        end
        seen = s2;
        s2 = s1;
        s1 = rx;
        if (s.m_ready && q.size() > 0) void'(q.pop_front());
        if (clr_overrun) m_ovr = 1'b0;
    endtask

    task automatic adv(int n);
        repeat (n) begin
            tick();
            if (mrst) return;
        end
    endtask

    task automatic mpush(logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    initial begin : model
        logic [7:0] b;
        forever begin
            do begin
                mrst = 1'b0;
                tick();
            end while (seen);
            adv(HALF);
            if (mrst || seen) continue;
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
                adv(CPB);
                if (mrst) break;
                b[i] = seen;
            end
            if (mrst) continue;
            adv(CPB);
            if (mrst) continue;
            if (seen) begin
                mpush(b);
            end else begin
                m_ferr = 1'b1;
                do tick(); while (!seen && !mrst);
            end
        end
    end

    always @(negedge clk) begin
        logic [13:0] act;
        logic [13:0] exp;
        if (rst_n && frame_err) nferr++;
        if (rst_n && chk_en) begin
            act = {s.m_valid, s.m_valid ? s.m_data : 8'h00,
                   level, overrun, frame_err};
            exp = {q.size() > 0, q.size() > 0 ? q[0] : 8'h00,
                   3'(q.size()), m_ovr, m_ferr};
            chk("cycle", 32'(act), 32'(exp));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b, logic stop);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        rx = stop;
        cyc(CPB);
    endtask

    task automatic pop1();
        s.m_ready = 1'b1;
        cyc(1);
        s.m_ready = 1'b0;
    endtask

    int n0;

    initial begin
        s.m_ready = 1'b0;
        cyc(3);
        chk("rst_valid", s.m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        cyc(5);

        // single byte, pinned at T0+4124
        fork
            send(8'hA5, 1'b1);
            begin
                cyc(4125);
                chk("t1_early", s.m_valid, 0);
                cyc(1);
                chk("t1_valid", s.m_valid, 1);
                chk("t1_data", s.m_data, 8'hA5);
                chk("t1_level", level, 1);
            end
        join
        pop1();
        chk("t1_empty", s.m_valid, 0);

        // burst of five into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        cyc(5);
        chk("t2_level", level, 4);
        chk("t2_ovr", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_pop", s.m_data, i);
            pop1();
        end
        chk("t2_empty", s.m_valid, 0);
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
        chk("t2_clr", overrun, 0);

        // framing error followed by a long break
        n0 = nferr;
        fork
            send(8'h3C, 1'b0);
            begin
                cyc(4125);
                chk("t3_fe_pre", frame_err, 0);
                cyc(1);
                chk("t3_fe", frame_err, 1);
                cyc(1);
                chk("t3_fe_post", frame_err, 0);
            end
        join
        cyc(20 * CPB);
        rx = 1'b1;
        cyc(10);
        chk("t3_nfe", nferr - n0, 1);
        chk("t3_level", level, 0);
        send(8'h55, 1'b1);
        cyc(3);
        chk("t3_data", s.m_data, 8'h55);
        pop1();

        // start-bit glitch
        n0 = nferr;
        rx = 1'b0;
        cyc(100);
        rx = 1'b1;
        cyc(300);
        chk("t4_valid", s.m_valid, 0);
        chk("t4_nfe", nferr - n0, 0);
        send(8'hFF, 1'b1);
        cyc(3);
        chk("t4_data", s.m_data, 8'hFF);
        chk("t4_level", level, 1);
        pop1();

        // full FIFO with a pop on the fifth stop sample
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b1);
        fork
            send(8'h14, 1'b1);
            begin
                cyc(4125);
                s.m_ready = 1'b1;
                cyc(1);
                s.m_ready = 1'b0;
            end
        join
        chk("t5_ovr", overrun, 0);
        chk("t5_level", level, 4);
        for (int i = 1; i <= 4; i++) begin
            chk("t5_pop", s.m_data, 8'h10 + i);
            pop1();
        end

        // reset during data bit 3 of 0x81
        send(8'h81, 1'b1);
        cyc(2);
        chk("t6_pre", level, 1);
        n0 = nferr;
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = (i == 0);
            cyc(CPB);
        end
        rx = 1'b0;
        cyc(200);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", s.m_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_ferr", frame_err, 0);
        chk("t6_ovr", overrun, 0);
        cyc(3);
        rx = 1'b1;
        rst_n = 1'b1;
        cyc(5000);
        chk("t6_after", s.m_valid, 0);
        chk("t6_nfe", nferr - n0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte-oriented UART receiver for the Murax test designs: it samples the SoC's `tx` line and delivers received bytes to fabric logic (LED/status display, loopback checkers) through a valid/ready stream. It is the receiving end of the Murax UART transmitter and uses 8N1 framing, LSB first, with mid-bit sampling. A small show-ahead FIFO absorbs bursts; framing and overrun errors are reported.

## Interface

- `CLK_HZ`, 50000000, frequency of `clk` in Hz.
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD` (434 at defaults), must be ≥ 8.
- `FIFO_DEPTH`, 4, FIFO entries; power of two, ≥ 2.

Ports:

- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous assert, active-low reset. Deassertion is synchronised externally.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `m_data` output 8: byte at the FIFO head. Valid only while `m_valid` is high.
- `m_valid` output 1: FIFO not empty.
- `m_ready` input 1: consumer accepts the head byte when `m_valid && m_ready`.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` output 1: sticky flag, set when a good byte arrives with the FIFO full.
- `clr_overrun` input 1: synchronous clear of `overrun`.
- `level` output `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation

- **Input path.** `rx` passes through a 2-flop synchroniser, reset value 1. All decisions below use the synchronised value `rxs`.
- **Bit timer.** Counts 0 to `CLKS_PER_BIT-1`. It is reloaded on every state entry.
- **IDLE.** Waits for `rxs == 0`, then enters START with the timer set to count `CLKS_PER_BIT/2` cycles (217).
- **START.** At half-bit expiry, samples `rxs`:
  - 0: enter DATA with bit index 0.
  - 1: glitch; return to IDLE with no output and no error.
- **DATA.** Every `CLKS_PER_BIT` cycles, samples `rxs` into the shift register at position `bit_idx` (LSB first). After bit 7 it enters STOP.
- **STOP.** After `CLKS_PER_BIT` cycles, samples `rxs`:
  - 1: push the byte into the FIFO and return to IDLE.
  - 0: pulse `frame_err`, discard the byte, and enter BREAK.
- **BREAK.** Waits until `rxs == 1`, then returns to IDLE. Held-low lines such as break conditions produce exactly one `frame_err`.
- **Push with FIFO full.**
  - If a pop happens in the same cycle, the push is accepted and `level` is unchanged.
  - Otherwise the byte is dropped and `overrun` is set.
  - `overrun` is cleared only by `clr_overrun` or reset. If set and clear occur in the same cycle, set wins.
- **FIFO.** Show-ahead: `m_data` shows the head entry combinationally from storage.
  - Pop: `m_valid && m_ready`.
  - Simultaneous push and pop with the FIFO empty: the pop is impossible since `m_valid = 0`, and the push lands.
- **Pointers.** Wrap modulo `FIFO_DEPTH`. `level` = number of pushes minus number of pops, and never exceeds `FIFO_DEPTH`.
- **Reset** (any time, including mid-frame):
  - State returns to IDLE; timer, bit index and shift register are cleared.
  - FIFO is emptied: `m_valid = 0`, `level = 0`, `m_data = 0`.
  - `frame_err = 0`, `overrun = 0`.
  - A frame interrupted by reset is lost. If `rx` is low after reset is released, the remaining low time is treated as a new start bit and validated by START.

## Timing

- Synchroniser latency: 2 cycles from an `rx` edge to `rxs`.
- Sample points, counted from the first `rxs == 0` cycle (T0):
  - start bit: T0+217;
  - data bit n: T0+217+(n+1)·434;
  - stop bit: T0+217+9·434 = T0+4123.
- The FIFO write happens on the stop-sample edge. `m_valid` rises and `level` increments on the next cycle (T0+4124).
- `frame_err` is high for exactly the cycle following the stop sample.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so the next start edge is detected with no lost frames. Baud mismatch tolerance is about ±4%.
- Throughput: one pop per cycle is sustained; `m_ready` has no combinational path to `rx`.

## Test plan

- **Single byte.** Reset, drive 0xA5 as 8N1 at 434 clk/bit with `m_ready = 0`. Required: `m_valid = 1`, `m_data = 0xA5`, `level = 1` at T0+4124; after one `m_ready` cycle, `m_valid = 0`.
- **Burst and overrun.** Drive 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with `m_ready = 0`. Required: `level = 4` and `overrun = 1` after the fifth byte; popping yields 0x01–0x04 in order. Then pulse `clr_overrun`: `overrun = 0`.
- **Framing error.** Drive 0x3C with the stop bit low, then hold `rx` low for 20 bit times, then high. Required: exactly one `frame_err` pulse at T0+4124, `level` stays 0, and the next valid byte 0x55 is received correctly.
- **Glitch rejection.** Drive `rx` low for 100 cycles, then high. Required: return to IDLE, no `m_valid`, no `frame_err`; a subsequent 0xFF frame is received correctly.
- **Full with simultaneous pop.** Fill the FIFO with 4 bytes. Hold `m_ready = 1` only during the cycle of the fifth stop sample. Required: `overrun = 0`, `level` remains 4, and the fifth byte is retained.
- **Reset mid-frame.** Assert `rst_n = 0` during data bit 3 of 0x81, release, and keep `rx` high. Required: all outputs return to reset values immediately (`m_valid = 0`, `level = 0`, `frame_err = 0`, `overrun = 0`), with no spurious byte afterwards.
